key_loader: RTL and testbench
=============================

Name: key_loader

Overview:
- Provisions the unlock key consumed by the team's key-locked datapath blocks.
- Accepts the key as a serial bit stream, with a valid/ready handshake, MSB first, followed by one even-parity bit.
- Checks parity, then presents the key in parallel with a valid flag.
- Counts failed loads and enters a permanent lockout after too many failures; only reset clears lockout.

Parameters:
- KEY_W, 8: key width in bits (at least 2).
- MAX_FAIL, 3: consecutive parity failures that trigger lockout (at least 1).

Ports:
- clk  in  1: clock; all state changes on rising edge.
- rst  in  1: reset. Asynchronous, active-low: rst=0 resets immediately.
- load_start  in  1: request a new key load. Accepted in IDLE or ARMED only.
- clear  in  1: wipe the key or abort a load. Ignored in LOCKOUT.
- ser_valid  in  1: ser_data holds a valid key bit.
- ser_data  in  1: serial key/parity bit.
- ser_ready  out  1: loader accepts a bit this cycle.
- key  out  KEY_W: key to the locked datapath; 0 whenever key_valid=0.
- key_valid  out  1: key is loaded and parity-checked.
- busy  out  1: high in SHIFT and CHECK.
- err  out  1: last load failed parity; sticky until the next load_start.
- lockout  out  1: permanent lockout until reset.
- fail_cnt  out  $clog2(MAX_FAIL+1): consecutive failed loads.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0, including key, key_valid, ser_ready, busy, err, lockout and fail_cnt. Shift register and bit counter are cleared.
- States: IDLE, SHIFT, CHECK, ARMED, LOCKOUT. All outputs are registered except ser_ready, which is high iff state==SHIFT.
- IDLE, load_start=1, clear=0:
  - Next state SHIFT; bit count := 0; shift register := 0.
  - err := 0; busy := 1.
- SHIFT:
  - A bit is accepted on an edge where ser_valid & ser_ready; the shift register shifts left with ser_data entering at the LSB.
  - Bits 0..KEY_W-1 are key bits, MSB first. Bit KEY_W is the parity bit, held in a separate flop.
  - Cycles with ser_valid=0 cause no change, so gaps are allowed.
  - On the edge that accepts the parity bit: next state CHECK.
  - load_start is ignored.
- CHECK (exactly one cycle); compute XOR of the KEY_W key bits and the parity bit:
  - XOR=0 (pass): key := shift register; key_valid := 1; fail_cnt := 0; busy := 0; next state ARMED.
  - XOR=1 (fail): err := 1; fail_cnt := fail_cnt+1; busy := 0; key and key_valid stay 0.
  - After a fail, if the new fail_cnt == MAX_FAIL: lockout := 1 and next state LOCKOUT; otherwise next state IDLE.
- Latency: if the parity bit is accepted on edge N, key_valid/err update on edge N+1 and are visible after N+1.
- ARMED:
  - key is held stable.
  - clear=1: key := 0; key_valid := 0; next state IDLE.
  - load_start=1 (clear=0): key := 0; key_valid := 0; next state SHIFT, same initialisation as from IDLE.
- LOCKOUT: all inputs ignored; ser_ready=0, key=0, key_valid=0, lockout=1. Exit only via rst.
- clear in SHIFT or CHECK: abort to IDLE; busy := 0; partial data discarded; fail_cnt and err unchanged. A CHECK-cycle clear overrides the check result.
- clear and load_start in the same cycle: clear wins; load_start is dropped.
- clear in IDLE: no effect.
- fail_cnt saturates at MAX_FAIL and resets only on a passing load or rst.
- A successful load never occurs with lockout=1.

Test Plan (KEY_W=8, MAX_FAIL=3):
1. Pulse load_start, then stream 1,0,1,0,0,1,0,1 plus parity 0 with ser_valid held high.
   -> Edge after parity acceptance: key=0xA5, key_valid=1, busy=0, err=0, fail_cnt=0.
   -> ser_ready high for exactly 9 cycles.
2. Same stream as scenario 1 with ser_valid low for 3 cycles between each bit.
   -> Same final result, key=0xA5. No bit is lost or duplicated; key stays 0 until CHECK completes.
3. Stream 0xA5 with parity 1.
   -> err=1, fail_cnt=1, key_valid=0, key=0, state IDLE.
   -> Then a good load of 0x3C with parity 0 gives key=0x3C, fail_cnt=0, err=0.
4. Three consecutive bad-parity loads.
   -> After the third CHECK: lockout=1, fail_cnt=3.
   -> A following load_start plus a good stream gives ser_ready=0 and key_valid=0 throughout.
   -> rst=0 clears lockout and fail_cnt.
5. Load 0xA5, then mid-reload (after 4 bits) assert clear and load_start together.
   -> Abort to IDLE; key=0, key_valid=0, fail_cnt unchanged, busy=0.
   -> A subsequent full load of 0x0F (parity 0) succeeds.
6. Drive rst=0 asynchronously (between clock edges) in the middle of SHIFT.
   -> All outputs go to 0 before the next clk edge.
   -> After rst=1, a load of 0xFF (parity 0) completes normally.

Source files
------------

// File: rtl/key_loader.sv
// Key loader: receives an unlock key as a serial stream (MSB first plus one
// even-parity bit), checks parity, and presents the key in parallel.
// Consecutive parity failures are counted; reaching MAX_FAIL locks the block
// until reset.
module key_loader #(
    parameter int KEY_W    = 8,
    parameter int MAX_FAIL = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_start,
    input  logic                          clear,
    input  logic                          ser_valid,
    input  logic                          ser_data,
    output logic                          ser_ready,
    output logic [KEY_W-1:0]              key,
    output logic                          key_valid,
    output logic                          busy,
    output logic                          err,
    output logic                          lockout,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int CNT_W  = $clog2(KEY_W + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        ARMED,
        LOCKOUT
    } state_t;

    state_t             state, state_d;
    logic [KEY_W-1:0]   shift_reg, shift_d;
    logic [KEY_W-1:0]   key_d;
    logic [CNT_W-1:0]   bit_cnt, cnt_d;
    logic               parity_q, parity_d;
    logic               key_valid_d, busy_d, err_d, lockout_d;
    logic [FAIL_W-1:0]  fail_d, fail_inc;
    logic               parity_ok;

    // Even parity: key bits XOR parity bit must be zero for a good load.
    assign parity_ok = ~(^shift_reg ^ parity_q);
    // Failure count saturates at MAX_FAIL.
    assign fail_inc  = (fail_cnt == FAIL_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + FAIL_W'(1);
    // The only unregistered output: bits are accepted only while shifting.
    assign ser_ready = (state == SHIFT);

    // Next-state and next-register values; every register holds by default.
    always_comb begin
        state_d     = state;
        shift_d     = shift_reg;
        cnt_d       = bit_cnt;
        parity_d    = parity_q;
        key_d       = key;
        key_valid_d = key_valid;
        busy_d      = busy;
        err_d       = err;
        lockout_d   = lockout;
        fail_d      = fail_cnt;
        case (state)
            IDLE: begin
                if (load_start && !clear) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (clear) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    shift_d = '0;
                end else if (ser_valid) begin
                    if (bit_cnt == CNT_W'(KEY_W)) begin
                        parity_d = ser_data;
                        state_d  = CHECK;
                    end else begin
                        shift_d = {shift_reg[KEY_W-2:0], ser_data};
                        cnt_d   = bit_cnt + CNT_W'(1);
                    end
                end
            end
            CHECK: begin
                busy_d = 1'b0;
                if (clear) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    shift_d = '0;
                end else if (parity_ok) begin
                    key_d       = shift_reg;
                    key_valid_d = 1'b1;
                    fail_d      = '0;
                    state_d     = ARMED;
                end else begin
                    err_d  = 1'b1;
                    fail_d = fail_inc;
                    if (fail_inc == FAIL_W'(MAX_FAIL)) begin
                        lockout_d = 1'b1;
                        state_d   = LOCKOUT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ARMED: begin
                if (clear) begin
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (load_start) begin
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    state_d     = SHIFT;
                    cnt_d       = '0;
                    shift_d     = '0;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            LOCKOUT: begin
                key_d       = '0;
                key_valid_d = 1'b0;
                busy_d      = 1'b0;
                lockout_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by active-low rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            parity_q  <= 1'b0;
            key       <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            lockout   <= 1'b0;
            fail_cnt  <= '0;
        end else begin
            state     <= state_d;
            shift_reg <= shift_d;
            bit_cnt   <= cnt_d;
            parity_q  <= parity_d;
            key       <= key_d;
            key_valid <= key_valid_d;
            busy      <= busy_d;
            err       <= err_d;
            lockout   <= lockout_d;
            fail_cnt  <= fail_d;
        end
    end

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader: directed scenarios followed by random
// loads, compared against a transaction-level model of expected outputs.
module tb_key_loader;

    logic       clk;
    logic       rst;
    logic       load_start;
    logic       clear;
    logic       ser_valid;
    logic       ser_data;
    logic       ser_ready;
    logic [7:0] key;
    logic       key_valid;
    logic       busy;
    logic       err;
    logic       lockout;
    logic [1:0] fail_cnt;

    int checks = 0;
    int passes = 0;
    int rdy_cycles = 0;

    // Reference model state
    logic [7:0] exp_key;
    logic       exp_valid;
    logic       exp_busy;
    logic       exp_err;
    logic       exp_lock;
    int         exp_fail;

    key_loader #(.KEY_W(8), .MAX_FAIL(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .clear      (clear),
        .ser_valid  (ser_valid),
        .ser_data   (ser_data),
        .ser_ready  (ser_ready),
        .key        (key),
        .key_valid  (key_valid),
        .busy       (busy),
        .err        (err),
        .lockout    (lockout),
        .fail_cnt   (fail_cnt)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts cycles in which the loader offers ser_ready
    always @(negedge clk) begin
        if (ser_ready === 1'b1) rdy_cycles++;
    end

    // Safety net so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".key"},       32'(key),       32'(exp_key));
        checkOutput({tag, ".key_valid"}, 32'(key_valid), 32'(exp_valid));
        checkOutput({tag, ".busy"},      32'(busy),      32'(exp_busy));
        checkOutput({tag, ".err"},       32'(err),       32'(exp_err));
        checkOutput({tag, ".lockout"},   32'(lockout),   32'(exp_lock));
        checkOutput({tag, ".fail_cnt"},  32'(fail_cnt),  32'(exp_fail));
    endtask

    task automatic modelReset();
        exp_key = 8'h00; exp_valid = 1'b0; exp_busy = 1'b0;
        exp_err = 1'b0;  exp_lock = 1'b0;  exp_fail = 0;
    endtask

    // Advance one clock; return 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulseReset(input string tag);
        #2 rst = 1'b0;
        #1;
        modelReset();
        checkAll(tag);
        checkOutput({tag, ".ser_ready"}, 32'(ser_ready), 32'd0);
        #2 rst = 1'b1;
    endtask

    // One load attempt; abort_at 0..8 = clear+load_start before that bit,
    // 9 = clear during CHECK, -1 = no abort
    task automatic applyStimulus(input logic [7:0] kv, input logic par, input int gap, input int abort_at);
        logic [8:0] bits;
        int         r0;
        bits = {kv, par};
        load_start = 1'b1; step(); load_start = 1'b0;
        if (!exp_lock) begin
            exp_key = 8'h00; exp_valid = 1'b0; exp_err = 1'b0; exp_busy = 1'b1;
        end
        checkOutput("start.ser_ready", 32'(ser_ready), 32'(!exp_lock));
        checkAll("start");
        r0 = rdy_cycles;
        for (int i = 0; i < 9; i++) begin
            if (i == abort_at) begin
                clear = 1'b1; load_start = 1'b1; step(); clear = 1'b0; load_start = 1'b0;
                if (!exp_lock) exp_busy = 1'b0;
                checkAll("abort_shift");
                return;
            end
            ser_valid = 1'b0;
            repeat (gap) step();
            ser_valid = 1'b1; ser_data = bits[8-i]; step(); ser_valid = 1'b0;
            if (i == 4) checkAll("mid_shift");
        end
        checkOutput("ready_cycles", 32'(rdy_cycles - r0), exp_lock ? 32'd0 : 32'(9 * (gap + 1)));
        if (abort_at == 9) begin
            clear = 1'b1; step(); clear = 1'b0;
            if (!exp_lock) exp_busy = 1'b0;
            checkAll("abort_check");
            return;
        end
        step();
        if (!exp_lock) begin
            exp_busy = 1'b0;
            if ((($countones(kv) + int'(par)) % 2) == 0) begin
                exp_key = kv; exp_valid = 1'b1; exp_err = 1'b0; exp_fail = 0;
            end else begin
                exp_err = 1'b1;
                exp_fail = (exp_fail < 3) ? exp_fail + 1 : 3;
                if (exp_fail == 3) exp_lock = 1'b1;
            end
        end
        checkAll("result");
    endtask

    // Pulse clear for one cycle
    task automatic clearKey();
        clear = 1'b1; step(); clear = 1'b0;
        if (!exp_lock) begin
            exp_key = 8'h00; exp_valid = 1'b0; exp_busy = 1'b0;
        end
        checkAll("clear");
    endtask

    initial begin
        logic [7:0] kv;
        logic       par;
        int         ab;
        load_start = 1'b0; clear = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;
        rst = 1'b0;
        #3;
        modelReset();
        checkAll("reset");
        checkOutput("reset.ser_ready", 32'(ser_ready), 32'd0);
        #4 rst = 1'b1;
        step();

        // Good load, back-to-back bits
        applyStimulus(8'hA5, 1'b0, 0, -1);
        // Same load with gaps, started from ARMED
        applyStimulus(8'hA5, 1'b0, 3, -1);
        // Bad parity, then a good load
        applyStimulus(8'hA5, 1'b1, 0, -1);
        applyStimulus(8'h3C, 1'b0, 0, -1);
        // Three bad loads reach lockout; good load is then ignored
        applyStimulus(8'hA5, 1'b1, 0, -1);
        applyStimulus(8'hA5, 1'b1, 1, -1);
        applyStimulus(8'h5A, 1'b1, 0, -1);
        applyStimulus(8'hA5, 1'b0, 0, -1);
        clearKey();
        pulseReset("lock_reset");
        step();
        // Abort mid-reload with clear+load_start, then a good load
        applyStimulus(8'hA5, 1'b0, 0, -1);
        applyStimulus(8'hA5, 1'b0, 0, 4);
        applyStimulus(8'h0F, 1'b0, 0, -1);
        // Clear in ARMED, clear during CHECK after a failure
        clearKey();
        applyStimulus(8'h01, 1'b0, 0, -1);
        applyStimulus(8'h81, 1'b0, 0, 9);
        // Async reset in the middle of SHIFT, then a good load
        load_start = 1'b1; step(); load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ser_valid = 1'b1; ser_data = 1'b1; step();
        end
        ser_valid = 1'b0;
        pulseReset("async_reset");
        step();
        applyStimulus(8'hFF, 1'b0, 0, -1);

        // Random loads
        for (int n = 0; n < 40; n++) begin
            kv  = 8'($urandom);
            par = 1'($countones(kv) % 2);
            if ($urandom_range(0, 9) < 3) par = ~par;
            ab  = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, 9)) : -1;
            applyStimulus(kv, par, int'($urandom_range(0, 2)), ab);
            if ($urandom_range(0, 9) < 2) clearKey();
            if (exp_lock && $urandom_range(0, 1) == 1) begin
                pulseReset("rand_reset");
                step();
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
